// File: rtl/vital_pkg.sv
// Shared definitions for the vital-sign monitor front-end: channel indices,
// sample width and the common sample/channel types.
package vital_pkg;

  localparam int NCH      = 6;
  localparam int SAMPLE_W = 8;
  localparam int CH_W     = 3;

  localparam int CH_H = 0;
  localparam int CH_P = 1;
  localparam int CH_O = 2;
  localparam int CH_T = 3;
  localparam int CH_R = 4;
  localparam int CH_B = 5;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [CH_W-1:0]     ch_idx_t;

  // Channel codes 6 and 7 exist on the 3-bit bus but map to no sensor.
  function automatic logic ch_is_valid(input ch_idx_t ch);
    return (int'(ch) < NCH);
  endfunction

endpackage

// File: rtl/vital_risk_qualifier_if.sv
// Serialized raw sensor sample bus: one (channel, reading) pair per cycle,
// no back-pressure.
interface vital_risk_qualifier_if;

  logic              sample_valid;
  vital_pkg::ch_idx_t sample_ch;
  vital_pkg::sample_t sample_data;

  modport master (
    output sample_valid,
    output sample_ch,
    output sample_data
  );

  modport slave (
    input sample_valid,
    input sample_ch,
    input sample_data
  );

endinterface

// File: rtl/vital_risk_qualifier_risk_channel.sv
// One sensor channel: window compare with hysteresis, consecutive-sample
// persistence filter and a staleness watchdog; risk is a pure register output.
module risk_channel
  import vital_pkg::*;
#(
  parameter int HYST    = 4,
  parameter int PERSIST = 3,
  parameter int TIMEOUT = 1000
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  sample_t data,
  input  sample_t thr_hi,
  input  sample_t thr_lo,
  output logic    risk,
  output logic    stale
);

  localparam logic [8:0]  HYST9    = 9'(HYST);
  localparam logic [3:0]  PERSIST4 = 4'(PERSIST);
  localparam logic [15:0] TIMEOUT16 = 16'(TIMEOUT);

  logic [8:0]  d9;
  logic [8:0]  hi9;
  logic [8:0]  lo9;
  logic [8:0]  hi_in9;
  logic [8:0]  lo_in9;
  logic        oor;

  logic        flag_reg;
  logic        flag_next;
  logic [3:0]  cnt_reg;
  logic [3:0]  cnt_next;
  logic [15:0] wd_reg;
  logic [15:0] wd_next;
  logic        stale_reg;
  logic        stale_next;
  logic        risk_reg;

  // Shrunken release window, saturating at the 8-bit range ends.
  always_comb begin
    d9     = {1'b0, data};
    hi9    = {1'b0, thr_hi};
    lo9    = {1'b0, thr_lo};
    lo_in9 = lo9 + HYST9;
    if (lo_in9 > 9'd255) begin
      lo_in9 = 9'd255;
    end
    hi_in9 = (hi9 >= HYST9) ? (hi9 - HYST9) : 9'd0;
    if (flag_reg) begin
      oor = (d9 > hi_in9) || (d9 < lo_in9);
    end else begin
      oor = (d9 > hi9) || (d9 < lo9);
    end
  end

  always_comb begin
    flag_next = flag_reg;
    cnt_next  = cnt_reg;
    if (en) begin
      if (oor == flag_reg) begin
        cnt_next = 4'd0;
      end else if (cnt_reg + 4'd1 == PERSIST4) begin
        flag_next = ~flag_reg;
        cnt_next  = 4'd0;
      end else begin
        cnt_next = cnt_reg + 4'd1;
      end
    end
  end

  // A sample both restarts the watchdog and drops stale on the same edge.
  always_comb begin
    if (en) begin
      wd_next = 16'd0;
    end else if (wd_reg < TIMEOUT16) begin
      wd_next = wd_reg + 16'd1;
    end else begin
      wd_next = wd_reg;
    end
    stale_next = !en && (wd_reg == TIMEOUT16);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_reg  <= 1'b0;
      cnt_reg   <= 4'd0;
      wd_reg    <= 16'd0;
      stale_reg <= 1'b0;
      risk_reg  <= 1'b0;
    end else begin
      flag_reg  <= flag_next;
      cnt_reg   <= cnt_next;
      wd_reg    <= wd_next;
      stale_reg <= stale_next;
      risk_reg  <= flag_next | stale_next;
    end
  end

  assign risk  = risk_reg;
  assign stale = stale_reg;

endmodule

// File: rtl/vital_risk_qualifier.sv
// Front-end of the vital-sign monitor: decodes the serialized sample stream
// into six qualified risk flags, per-channel stale indications and err_ch.
module vital_risk_qualifier
  import vital_pkg::*;
#(
  parameter logic [NCH*SAMPLE_W-1:0] THR_HI = {NCH{8'd120}},
  parameter logic [NCH*SAMPLE_W-1:0] THR_LO = {NCH{8'd50}},
  parameter int HYST    = 4,
  parameter int PERSIST = 3,
  parameter int TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  vital_risk_qualifier_if.slave  smp,
  output logic                   H,
  output logic                   P,
  output logic                   O,
  output logic                   T,
  output logic                   R,
  output logic                   B,
  output logic [NCH-1:0]         stale,
  output logic                   err_ch
);

  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] risk;
  logic [NCH-1:0] stale_w;
  logic           err_reg;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_en[gi] = smp.sample_valid && (smp.sample_ch == CH_W'(gi));

      risk_channel #(
        .HYST    (HYST),
        .PERSIST (PERSIST),
        .TIMEOUT (TIMEOUT)
      ) u_ch (
        .clk    (clk),
        .reset  (reset),
        .en     (ch_en[gi]),
        .data   (smp.sample_data),
        .thr_hi (THR_HI[gi*SAMPLE_W +: SAMPLE_W]),
        .thr_lo (THR_LO[gi*SAMPLE_W +: SAMPLE_W]),
        .risk   (risk[gi]),
        .stale  (stale_w[gi])
      );
    end
  endgenerate

  // Invalid channel codes touch no channel state; they only raise err_ch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= smp.sample_valid && !ch_is_valid(smp.sample_ch);
    end
  end

  assign H      = risk[CH_H];
  assign P      = risk[CH_P];
  assign O      = risk[CH_O];
  assign T      = risk[CH_T];
  assign R      = risk[CH_R];
  assign B      = risk[CH_B];
  assign stale  = stale_w;
  assign err_ch = err_reg;

endmodule

// File: tb/tb_vital_risk_qualifier.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor
// pops and compares the DUT outputs after every clock edge.
module tb_vital_risk_qualifier;

  localparam int HYST    = 4;
  localparam int PERSIST = 3;
  localparam int TIMEOUT = 1000;
  // Channel 0 uses 50..120; channel 5 has an inverted window near the rails.
  localparam logic [47:0] TB_HI = {8'd2,   8'd200, 8'd180, 8'd160, 8'd140, 8'd120};
  localparam logic [47:0] TB_LO = {8'd254, 8'd40,  8'd60,  8'd80,  8'd60,  8'd50};

  logic       clk;
  logic       reset;
  logic       H, P, O, T, R, B;
  logic [5:0] stale;
  logic       err_ch;

  vital_risk_qualifier_if sif ();

  vital_risk_qualifier #(
    .THR_HI  (TB_HI),
    .THR_LO  (TB_LO),
    .HYST    (HYST),
    .PERSIST (PERSIST),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .smp    (sif.slave),
    .H      (H),
    .P      (P),
    .O      (O),
    .T      (T),
    .R      (R),
    .B      (B),
    .stale  (stale),
    .err_ch (err_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  logic [12:0] exp_q[$];

  // Reference model: flag, run of disagreeing samples, idle edges per channel.
  bit flag_m[6];
  int run_m[6];
  int idle_m[6];

  function automatic int hi_of(input int c);
    logic [47:0] v;
    v = TB_HI;
    return int'(v[8*c +: 8]);
  endfunction

  function automatic int lo_of(input int c);
    logic [47:0] v;
    v = TB_LO;
    return int'(v[8*c +: 8]);
  endfunction

  function automatic logic [12:0] dut_out();
    return {err_ch, stale, B, R, T, O, P, H};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 6; c++) begin
      flag_m[c] = 1'b0;
      run_m[c]  = 0;
      idle_m[c] = 0;
    end
  endtask

  task automatic model_step(input bit v, input int ch, input int d, output logic [12:0] e);
    int hi, lo, hi_in, lo_in;
    bit oor;
    logic [5:0] r, s;
    for (int c = 0; c < 6; c++) begin
      if (v && ch == c) begin
        hi    = hi_of(c);
        lo    = lo_of(c);
        lo_in = (lo + HYST > 255) ? 255 : lo + HYST;
        hi_in = (hi - HYST < 0) ? 0 : hi - HYST;
        oor   = flag_m[c] ? (d > hi_in || d < lo_in) : (d > hi || d < lo);
        if (oor != flag_m[c]) begin
          run_m[c]++;
          if (run_m[c] >= PERSIST) begin
            flag_m[c] = !flag_m[c];
            run_m[c]  = 0;
          end
        end else begin
          run_m[c] = 0;
        end
        idle_m[c] = 0;
      end else if (idle_m[c] <= TIMEOUT) begin
        idle_m[c]++;
      end
      s[c] = (idle_m[c] > TIMEOUT);
      r[c] = flag_m[c] | s[c];
    end
    e = {(v && ch > 5), s, r};
  endtask

  task automatic drive(input bit v, input int ch, input int d);
    logic [12:0] e;
    @(negedge clk);
    sif.sample_valid = v;
    sif.sample_ch    = 3'(ch);
    sif.sample_data  = 8'(d);
    model_step(v, ch, d, e);
    exp_q.push_back(e);
  endtask

  // Asynchronous pulse between edges; outputs must read zero while asserted.
  task automatic do_reset();
    logic [12:0] e;
    @(negedge clk);
    sif.sample_valid = 1'b0;
    sif.sample_ch    = 3'd0;
    sif.sample_data  = 8'd0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (dut_out() !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b required %b", dut_out(), 13'd0);
    end
    #1;
    reset = 1'b0;
    model_reset();
    model_step(1'b0, 0, 0, e);
    exp_q.push_back(e);
  endtask

  function automatic int clamp8(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  function automatic int rand_data(input int c);
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 255));
      1:       return clamp8(hi_of(c) + int'($urandom_range(0, 16)) - 8);
      2:       return clamp8(lo_of(c) + int'($urandom_range(0, 16)) - 8);
      default: return (hi_of(c) + lo_of(c)) / 2;
    endcase
  endfunction

  // Monitor: one comparison per edge that has a pending expectation.
  initial begin
    logic [12:0] e;
    forever begin
      @(posedge clk);
      cycle++;
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (dut_out() !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got err/stale/risk %b required %b",
                   cycle, dut_out(), e);
        end
      end
    end
  end

  initial begin
    int ch;
    reset            = 1'b1;
    sif.sample_valid = 1'b0;
    sif.sample_ch    = 3'd0;
    sif.sample_data  = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Assert after three consecutive out-of-range samples.
    drive(1, 0, 130); drive(1, 0, 130); drive(1, 0, 130);
    drive(0, 0, 0);
    // Hysteresis: 118 is above 116 and still counts as risk.
    drive(1, 0, 130); drive(1, 0, 130); drive(1, 0, 118);
    drive(1, 0, 100); drive(1, 0, 100); drive(1, 0, 100);
    drive(0, 0, 0);
    // Filter rejection: an in-range sample restarts the count.
    drive(1, 0, 130); drive(1, 0, 130); drive(1, 0, 80);
    drive(1, 0, 130); drive(1, 0, 130);
    drive(0, 0, 0);
    // Invalid channels.
    drive(1, 7, 200); drive(0, 0, 0); drive(1, 6, 0); drive(1, 1, 100);

    // Watchdog on channel 0 while the others are fed every 10 cycles.
    for (int i = 0; i < 1020; i++) begin
      ch = i % 10;
      if (ch >= 1 && ch <= 5) drive(1, ch, (hi_of(ch) + lo_of(ch)) / 2);
      else                    drive(0, 0, 0);
    end
    drive(1, 0, 85);
    drive(0, 0, 0); drive(0, 0, 0);

    // Reset in the middle of a persistence run.
    drive(1, 0, 130); drive(1, 0, 130);
    do_reset();
    drive(1, 0, 130); drive(0, 0, 0);
    drive(1, 0, 130); drive(1, 0, 130); drive(0, 0, 0);

    // Random traffic over all channel codes.
    for (int i = 0; i < 3000; i++) begin
      ch = int'($urandom_range(0, 6));
      if (ch == 6 && $urandom_range(0, 1) == 1) ch = 7;
      drive($urandom_range(0, 9) < 7, ch, rand_data(ch > 5 ? 0 : ch));
    end
    // Random traffic that starves channels 4 and 5 into staleness.
    for (int i = 0; i < 1500; i++) begin
      ch = int'($urandom_range(0, 3));
      drive($urandom_range(0, 9) < 6, ch, rand_data(ch));
    end
    drive(1, 4, 100); drive(1, 5, 0); drive(0, 0, 0);

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vital_risk_qualifier.md
Name: vital_risk_qualifier

Overview:
- Upstream front-end of the vital-sign monitor FSM. Converts the serialized raw 8-bit sensor sample stream into the six qualified risk flags (1 = risk) that the FSM consumes.
- Sensor order: heart rate, pressure, oxygen, temperature, respiration, blood glucose.
- Per channel: window comparison with hysteresis, a consecutive-sample persistence filter, and a fail-safe staleness watchdog. A silent sensor is reported as risk.

Parameters:
- NCH, 6, number of sensor channels (fixed at 6; channel index 0..5 = H,P,O,T,R,B)
- THR_HI, packed 6x8 bits, per-channel upper limit; channel c occupies bits [8c+7:8c]
- THR_LO, packed 6x8 bits, per-channel lower limit, same packing
- HYST, 4, hysteresis margin in LSBs applied when clearing a flag
- PERSIST, 3, consecutive disagreeing samples required to change a flag (1..15)
- TIMEOUT, 1000, clk cycles without a sample before a channel goes stale (<2^16)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sample_valid  in  1  sample_ch/sample_data valid this cycle
- sample_ch  in  3  channel index 0..5
- sample_data  in  8  unsigned raw reading
- H, P, O, T, R, B  out  1 each  qualified risk flag, channels 0..5
- stale  out  6  per-channel watchdog expired
- err_ch  out  1  one-cycle pulse: valid sample with sample_ch > 5

Behaviour:
- Reset, asynchronous, active-high: all flags 0, persistence counters 0, watchdog counters 0, stale 0, err_ch 0. All outputs are therefore 0 while reset is asserted and after it is released.
- The block always accepts input; there is no back-pressure. At most one sample per cycle.
- Out-of-range evaluation for a sample d on channel c, given the current flag f[c]:
  - When f[c]=0: oor = (d > HI) or (d < LO).
  - When f[c]=1: oor = (d > HI-HYST) or (d < LO+HYST), so clearing needs the reading strictly inside the shrunken window.
  - Compare in 9-bit unsigned; LO+HYST and HI-HYST saturate at 255 and 0.
- Persistence, on each accepted sample for channel c:
  - If oor == f[c]: cnt[c] is cleared to 0.
  - Otherwise cnt[c] increments. When the increment would reach PERSIST, f[c] toggles and cnt[c] is cleared in the same edge.
- Watchdog:
  - wd[c] increments each cycle while wd[c] < TIMEOUT, and is cleared on the edge that accepts a sample for channel c.
  - stale[c] = (wd[c] == TIMEOUT), a registered compare.
  - A sample for c clears stale[c] at the next edge.
- Output: risk[c] = f[c] | stale[c], driven from registers with no combinational path from the inputs.
- Latency: a flag-changing sample at edge k is visible on the output after edge k; the FSM samples it at edge k+1.
- Invalid channel (6, 7) with sample_valid=1: no state change; err_ch=1 for exactly the following cycle.
- sample_valid=0: only the watchdogs advance.
- Back-to-back samples on the same channel are all counted. Samples on other channels never touch cnt[c] (no interleave penalty).
- Reset asserted mid-persistence: counters and flags cleared immediately; the count restarts from 0 after release.
- Timing: the FSM derives its any-risk term as the OR and its total-crisis term as the AND of the six flags. All six are updated from one register bank so that no glitches reach the FSM.

Decomposition:
- Shared package vital_pkg: channel index constants CH_H=0 .. CH_B=5, NCH, and the sample width of 8.
- One natural sub-module, risk_channel: one instance per channel, holding the comparator, hysteresis, persistence counter and watchdog. It takes a channel-enable strobe, the data, and the per-channel thresholds. The top level only decodes sample_ch, instantiates 6x risk_channel, and generates err_ch.

Test Plan:
All scenarios use THR_HI[ch0]=120, THR_LO[ch0]=50, HYST=4, PERSIST=3, TIMEOUT=1000.
- Assert: ch0 samples 130,130,130 on consecutive cycles → H=1 one cycle after the 3rd sample; cnt back to 0.
- Persistence and hysteresis release: with H=1, send ch0 samples 130,130,118 → H stays 1 (118 > 116); then 100,100,100 → H=0 after the 3rd.
- Filter rejection: ch0 samples 130,130,80,130,130 → H never asserts, because the 80 clears the counter.
- Watchdog: feed ch1..ch5 in-range every 10 cycles, no ch0 samples for 1000 cycles → stale[0]=1 and H=1. One in-range ch0 sample → stale[0]=0 and H=0 on the next edge.
- Invalid channel: sample_ch=7, data=200 → err_ch pulses for exactly 1 cycle; all flags and counters unchanged.
- Reset mid-operation: after two 130 samples on ch0, pulse reset asynchronously, release it, then send one 130 → H=0. Two more 130 samples are needed before H=1.
